// File: rtl/mp_types.sv
// Shared types for the systolic tile sequencer: FSM state encoding and the
// tile command record.
package mp_types;

  localparam int unsigned N_DEF    = 4;
  localparam int unsigned KMAX_DEF = 256;
  localparam int unsigned AW_DEF   = 10;
  localparam int unsigned TW_DEF   = 4;
  localparam int unsigned KW_DEF   = $clog2(KMAX_DEF + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_RESULT = 2'd3
  } tile_state_e;

  typedef struct packed {
    logic [AW_DEF-1:0] base;
    logic [KW_DEF-1:0] k;
    logic [TW_DEF-1:0] tag;
  } tile_cmd_t;

endpackage

// File: rtl/systolic_tile_ctrl.sv
// Sequencer for one NxN systolic array: issues K operand reads per tile, times
// the array valid / accumulator clear, and hands the finished tile to writeback.
module systolic_tile_ctrl
  import mp_types::*;
#(
  parameter int unsigned N    = N_DEF,
  parameter int unsigned KMAX = KMAX_DEF,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned TW   = TW_DEF
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [AW-1:0]             cmd_base,
  input  logic [$clog2(KMAX+1)-1:0] cmd_k,
  input  logic [TW-1:0]             cmd_tag,
  output logic                      op_rd_en,
  output logic [AW-1:0]             op_rd_addr,
  output logic                      arr_valid,
  output logic                      acc_clear,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [TW-1:0]             res_tag,
  output logic                      cmd_err,
  output logic                      busy,
  output logic [15:0]               tile_cnt
);

  localparam int unsigned KW = $clog2(KMAX + 1);

  if (N < 1 || KMAX < 1) begin : g_bad_param
    $error("systolic_tile_ctrl: N and KMAX must be at least 1");
  end

  tile_state_e   state_q;
  logic          started_q;
  logic          first_q;
  logic [KW-1:0] rd_left_q;
  logic          op_rd_en_q;
  logic [AW-1:0] op_rd_addr_q;
  logic          arr_valid_q;
  logic          acc_clear_q;
  logic          res_valid_q;
  logic [TW-1:0] res_tag_q;
  logic          cmd_err_q;
  logic [15:0]   tile_cnt_q;

  logic          cmd_accept;
  logic          cmd_legal;

  // started_q keeps cmd_ready low until the first edge after reset release.
  assign cmd_ready  = started_q && (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign cmd_accept = cmd_valid && cmd_ready;
  assign cmd_legal  = (cmd_k != '0) && (32'(cmd_k) <= KMAX);

  // Tile FSM with all registered outputs; arr_valid trails the read strobe by one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      started_q    <= 1'b0;
      first_q      <= 1'b0;
      rd_left_q    <= '0;
      op_rd_en_q   <= 1'b0;
      op_rd_addr_q <= '0;
      arr_valid_q  <= 1'b0;
      acc_clear_q  <= 1'b0;
      res_valid_q  <= 1'b0;
      res_tag_q    <= '0;
      cmd_err_q    <= 1'b0;
      tile_cnt_q   <= 16'd0;
    end else begin
      started_q   <= 1'b1;
      arr_valid_q <= op_rd_en_q;
      acc_clear_q <= op_rd_en_q && first_q;
      cmd_err_q   <= 1'b0;
      if (op_rd_en_q) begin
        first_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (cmd_accept) begin
            res_tag_q <= cmd_tag;
            if (cmd_legal) begin
              state_q      <= ST_FETCH;
              op_rd_en_q   <= 1'b1;
              op_rd_addr_q <= cmd_base;
              rd_left_q    <= cmd_k;
              first_q      <= 1'b1;
            end else begin
              cmd_err_q <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (rd_left_q == KW'(1)) begin
            op_rd_en_q <= 1'b0;
            state_q    <= ST_DRAIN;
          end else begin
            rd_left_q    <= rd_left_q - KW'(1);
            op_rd_addr_q <= op_rd_addr_q + AW'(1);
          end
        end
        ST_DRAIN: begin
          state_q     <= ST_RESULT;
          res_valid_q <= 1'b1;
        end
        ST_RESULT: begin
          if (res_valid_q && res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
            tile_cnt_q  <= tile_cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign op_rd_en   = op_rd_en_q;
  assign op_rd_addr = op_rd_addr_q;
  assign arr_valid  = arr_valid_q;
  assign acc_clear  = acc_clear_q;
  assign res_valid  = res_valid_q;
  assign res_tag    = res_tag_q;
  assign cmd_err    = cmd_err_q;
  assign tile_cnt   = tile_cnt_q;

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic compared against
// a cycle-offset reference model of the tile schedule.
module tb_systolic_tile_ctrl;
  import mp_types::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_base = 10'd0;
  logic [8:0]  cmd_k = 9'd0;
  logic [3:0]  cmd_tag = 4'd0;
  logic        op_rd_en;
  logic [9:0]  op_rd_addr;
  logic        arr_valid;
  logic        acc_clear;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [3:0]  res_tag;
  logic        cmd_err;
  logic        busy;
  logic [15:0] tile_cnt;

  systolic_tile_ctrl dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base),
    .cmd_k(cmd_k), .cmd_tag(cmd_tag),
    .op_rd_en(op_rd_en), .op_rd_addr(op_rd_addr),
    .arr_valid(arr_valid), .acc_clear(acc_clear),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
    .cmd_err(cmd_err), .busy(busy), .tile_cnt(tile_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;

  // Reference model: one outstanding tile, described by its accept cycle.
  bit          m_idle = 1'b1;
  int          m_acc = 0;
  tile_cmd_t   m_cmd;
  bit          m_err = 1'b0;
  logic [15:0] m_cnt = 16'd0;

  bit          rec = 1'b0;
  int          acc_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic tile_state_e model_state();
    int d;
    int k;
    d = cyc - m_acc;
    k = int'(m_cmd.k);
    if (m_idle) return ST_IDLE;
    if (d <= k) return ST_FETCH;
    if (d == k + 1) return ST_DRAIN;
    return ST_RESULT;
  endfunction

  task automatic check_outputs();
    tile_state_e st;
    int          d;
    int          k;
    logic [9:0]  ea;
    st = model_state();
    d  = cyc - m_acc;
    k  = int'(m_cmd.k);
    chk("cmd_ready", 32'(cmd_ready), 32'(st == ST_IDLE));
    chk("busy", 32'(busy), 32'(st != ST_IDLE));
    chk("op_rd_en", 32'(op_rd_en), 32'(st == ST_FETCH));
    if (st == ST_FETCH) begin
      ea = m_cmd.base + 10'(d - 1);
      chk("op_rd_addr", 32'(op_rd_addr), 32'(ea));
    end
    chk("arr_valid", 32'(arr_valid), 32'(!m_idle && d >= 2 && d <= k + 1));
    chk("acc_clear", 32'(acc_clear), 32'(!m_idle && d == 2));
    chk("res_valid", 32'(res_valid), 32'(st == ST_RESULT));
    if (st == ST_RESULT) begin
      chk("res_tag", 32'(res_tag), 32'(m_cmd.tag));
    end
    chk("cmd_err", 32'(cmd_err), 32'(m_err));
    chk("tile_cnt", 32'(tile_cnt), 32'(m_cnt));
  endtask

  task automatic step(input logic v, input logic [9:0] b, input logic [8:0] k,
                      input logic [3:0] t, input logic rr);
    tile_state_e st;
    bit          err_next;
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
    cmd_valid = v;
    cmd_base  = b;
    cmd_k     = k;
    cmd_tag   = t;
    res_ready = rr;
    if (rec && cmd_valid && cmd_ready) acc_q.push_back(cyc);
    st = model_state();
    err_next = 1'b0;
    if (st == ST_IDLE && v) begin
      if (k == 9'd0 || k > 9'd256) begin
        err_next = 1'b1;
      end else begin
        m_idle     = 1'b0;
        m_acc      = cyc;
        m_cmd.base = b;
        m_cmd.k    = k;
        m_cmd.tag  = t;
      end
    end else if (st == ST_RESULT && rr) begin
      m_idle = 1'b1;
      m_cnt  = m_cnt + 16'd1;
    end
    m_err = err_next;
  endtask

  task automatic idle_steps(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(1'b0, 10'd0, 9'd0, 4'd0, rr);
  endtask

  task automatic reset_dut(input bit pre_check);
    @(posedge clk);
    #1;
    cyc++;
    if (pre_check) check_outputs();
    rstn      = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op_rd_en", 32'(op_rd_en), 32'd0);
    chk("rst_op_rd_addr", 32'(op_rd_addr), 32'd0);
    chk("rst_arr_valid", 32'(arr_valid), 32'd0);
    chk("rst_acc_clear", 32'(acc_clear), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_tag", 32'(res_tag), 32'd0);
    chk("rst_cmd_err", 32'(cmd_err), 32'd0);
    chk("rst_tile_cnt", 32'(tile_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn   = 1'b1;
    m_idle = 1'b1;
    m_err  = 1'b0;
    m_cnt  = 16'd0;
  endtask

  initial begin
    int          r;
    logic [8:0]  rk;
    logic [15:0] cnt0;

    reset_dut(1'b0);

    // Basic tile, then a tile whose addresses wrap past 1023.
    step(1'b1, 10'd0, 9'd4, 4'd3, 1'b1);
    idle_steps(8, 1'b1);
    step(1'b1, 10'd1022, 9'd4, 4'd9, 1'b1);
    idle_steps(8, 1'b1);

    // Backpressure with a second command pending the whole time.
    step(1'b1, 10'd5, 9'd2, 4'd7, 1'b0);
    for (int i = 0; i < 13; i++) step(1'b1, 10'd40, 9'd3, 4'd2, 1'b0);
    step(1'b1, 10'd40, 9'd3, 4'd2, 1'b1);
    step(1'b1, 10'd40, 9'd3, 4'd2, 1'b1);
    idle_steps(10, 1'b1);

    // Illegal depths, then the largest legal depth.
    step(1'b1, 10'd0, 9'd0, 4'd1, 1'b1);
    step(1'b0, 10'd0, 9'd0, 4'd0, 1'b1);
    step(1'b1, 10'd0, 9'd257, 4'd2, 1'b1);
    idle_steps(3, 1'b1);
    step(1'b1, 10'd900, 9'd256, 4'd4, 1'b1);
    idle_steps(262, 1'b1);

    // Reset during the third read, then a K=1 tile.
    step(1'b1, 10'd256, 9'd8, 4'd5, 1'b1);
    step(1'b0, 10'd0, 9'd0, 4'd0, 1'b1);
    step(1'b0, 10'd0, 9'd0, 4'd0, 1'b1);
    reset_dut(1'b1);
    step(1'b1, 10'd7, 9'd1, 4'd6, 1'b1);
    idle_steps(5, 1'b1);

    // Back-to-back K=2 tiles with writeback always ready.
    cnt0 = tile_cnt;
    acc_q.delete();
    rec = 1'b1;
    for (int i = 0; i < 15; i++) step(1'b1, 10'd12, 9'd2, 4'd1, 1'b1);
    rec = 1'b0;
    idle_steps(6, 1'b1);
    chk("b2b_accepts", 32'(acc_q.size()), 32'd3);
    for (int i = 1; i < acc_q.size(); i++) begin
      chk("b2b_spacing", 32'(acc_q[i] - acc_q[i-1]), 32'd5);
    end
    chk("b2b_tile_cnt", 32'(tile_cnt - cnt0), 32'd3);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 15));
      if (r == 0)      rk = 9'd0;
      else if (r == 1) rk = 9'(257 + $urandom_range(0, 254));
      else if (r == 2) rk = 9'($urandom_range(9, 40));
      else             rk = 9'($urandom_range(1, 8));
      step(1'($urandom_range(0, 99) < 30), 10'($urandom), rk, 4'($urandom),
           1'($urandom_range(0, 1)));
    end
    idle_steps(50, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/systolic_tile_ctrl.md
# systolic_tile_ctrl

Sequencer for one N×N `systolic_array` instance. It accepts a tile command (operand base address, reduction depth K, tag) and issues K consecutive operand reads. It then drives the array's `valid` and accumulator-clear timing so that `acc_out` holds the finished K-step dot-product tile. The result is presented to the writeback path through a valid/ready handshake. It sits between the command queue, the operand buffers and the array.

## Interface
- `N`, 4, array dimension (informational; passed through to the `res_*` consumer)
- `KMAX`, 256, largest legal reduction depth
- `AW`, 10, operand buffer address width
- `TW`, 4, command tag width
- `clk`  in  1  clock
- `rstn`  in  1  reset, asynchronous, active-low
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  controller can accept a command
- `cmd_base`  in  AW  first operand address
- `cmd_k`  in  $clog2(KMAX+1)  reduction depth
- `cmd_tag`  in  TW  opaque tag, echoed on result
- `op_rd_en`  out  1  operand buffer read strobe; a_row/b_col data returns the next cycle
- `op_rd_addr`  out  AW  operand read address
- `arr_valid`  out  1  drives the array `valid`
- `acc_clear`  out  1  datapath selects 0 instead of the `acc_out` feedback into `acc_in`
- `res_valid`  out  1  `acc_out` holds a finished tile
- `res_ready`  in  1  writeback has consumed the tile
- `res_tag`  out  TW  tag of the presented tile
- `cmd_err`  out  1  one-cycle pulse: illegal command dropped
- `busy`  out  1  state ≠ IDLE
- `tile_cnt`  out  16  completed tiles; wraps at 2^16

## Operation
- FSM states and transitions:
  - IDLE → FETCH on an accepted legal command.
  - FETCH → DRAIN after K reads.
  - DRAIN → RESULT after 1 cycle.
  - RESULT → IDLE on `res_valid && res_ready`.
- `cmd_ready` = (state == IDLE). Accept = `cmd_valid && cmd_ready`; `cmd_base`, `cmd_k` and `cmd_tag` are captured on accept.
- Illegal command (`cmd_k == 0` or `cmd_k > KMAX`): it is still accepted, `cmd_err` pulses the next cycle, state stays IDLE, there is no array activity and `tile_cnt` is unchanged.
- FETCH: `op_rd_en` = 1 and `op_rd_addr` = base + i for i = 0..K-1. The address adds modulo 2^AW, so base 1022 with K = 4 reads 1022, 1023, 0, 1.
- `arr_valid` is `op_rd_en` delayed by one register.
- `acc_clear` is high only together with the first `arr_valid` of a tile.
- Array behaviour between steps: the array holds `acc_out` while `arr_valid` = 0. The tile result therefore stays stable through RESULT with no further control needed.
- `res_tag` holds the captured tag from accept until the handshake completes.
- `tile_cnt` increments on each completed `res_valid && res_ready`.
- Reset, including reset asserted mid-tile: state → IDLE and all outputs → 0. `cmd_ready` rises on the first clock edge after `rstn` deasserts.

## Timing
- Accept at cycle T.
- Reads at cycles T+1 .. T+K.
- `arr_valid` at T+2 .. T+K+1; `acc_clear` at T+2 only.
- DRAIN at T+K+1.
- `res_valid` from T+K+2 onward until handshake.
- Minimum command-to-command spacing is K+3 cycles, reached with `res_ready` held high.
- `res_ready` low holds RESULT indefinitely. `res_ready` high while not in RESULT has no effect.
- A `cmd_valid` held through busy is accepted in the first IDLE cycle, i.e. the cycle after the result handshake.
- All outputs are registered, except `cmd_ready` and `busy`, which are decoded from the state register.

## Structure
- `mp_types` gains `tile_state_e` (IDLE, FETCH, DRAIN, RESULT) and `tile_cmd_t` (base, k, tag struct). The bench uses both.
- Single module. No sub-module is warranted: the step counter and address adder are a few lines each.
- The `acc_in` zero/feedback mux is owned by the datapath wrapper, not by this block.

## Test plan
- Reset, then base = 0, K = 4, tag = 3 at T → reads addr 0..3 at T+1..T+4; `arr_valid` at T+2..T+5; `acc_clear` only at T+2; `res_valid` at T+6 with `res_tag` = 3; `tile_cnt` = 1 after handshake.
- Address wrap: base = 1022, K = 4 → `op_rd_addr` sequence 1022, 1023, 0, 1.
- Backpressure: `res_ready` low for 10 cycles → `res_valid`, `res_tag` and `cmd_ready` = 0 stay stable; `arr_valid` stays 0; a `cmd_valid` pending throughout is accepted the cycle after the handshake.
- Illegal commands: K = 0, then K = 257 → `cmd_err` pulse for each; no `op_rd_en`; `busy` stays 0; `tile_cnt` unchanged.
- Reset asserted at the third FETCH cycle → all outputs 0 immediately. After release, a new K = 1 command completes with `res_valid` at accept+3.
- Back-to-back with `res_ready` = 1: 3 commands of K = 2 → accepts exactly 5 cycles apart; `tile_cnt` = 3.
